// File: rtl/ucsbece154_icache_rr.sv
// ucsbece154_icache_rr: set-associative instruction cache between the fetch
// stage and the SDRAM controller. Round-robin replacement per set, early
// restart on the requested beat, and whole-cache invalidate for fence.i.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | lookups accepted; hits answered next cycle, misses start a refill
// REFILL | line being fetched beat by beat; requests ignored, Busy high
module ucsbece154_icache_rr #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 ReadEnable,
    input  logic [31:0]          ReadAddress,
    input  logic                 Invalidate,
    output logic [WORD_SIZE-1:0] Instruction,
    output logic                 Ready,
    output logic                 Busy,
    output logic [31:0]          MemReadAddress,
    output logic                 MemReadRequest,
    input  logic [WORD_SIZE-1:0] MemDataIn,
    input  logic                 MemDataReady
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          HitCount,
    output logic [31:0]          MissCount
`endif
);

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int OFFSET = 2 + WORD_W;
    localparam int TAG_W  = 32 - OFFSET - SET_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BLOCK_WORDS - 1);

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t state;

    logic [WORD_SIZE-1:0] data_mem [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q  [NUM_SETS];
    logic [WAY_W-1:0]     rr_ptr   [NUM_SETS];

    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;

    logic [SET_W-1:0]  lat_set;
    logic [TAG_W-1:0]  lat_tag;
    logic [WORD_W-1:0] lat_word;
    logic [WAY_W-1:0]  lat_way;
    logic              lat_from_rr;
    logic              poisoned;
    logic [WORD_W-1:0] beat;

    logic              hit_any;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_any;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim_way;
    logic              victim_from_rr;
    logic              lookup_hit;
    logic              lookup_miss;
    logic              addr_unused;

    assign req_set     = ReadAddress[OFFSET+SET_W-1:OFFSET];
    assign req_tag     = ReadAddress[31:OFFSET+SET_W];
    assign req_word    = ReadAddress[OFFSET-1:2];
    assign addr_unused = ^ReadAddress[1:0];

    // Tag match and lowest-index invalid way for the requested set
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_set][w] && (tag_mem[req_set][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_set][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    // Victim choice; a coincident Invalidate empties the set, so way 0 is free
    always_comb begin
        victim_way     = rr_ptr[req_set];
        victim_from_rr = 1'b1;
        if (Invalidate) begin
            victim_way     = '0;
            victim_from_rr = 1'b0;
        end else if (inv_any) begin
            victim_way     = inv_way;
            victim_from_rr = 1'b0;
        end
    end

    assign lookup_hit  = (state == S_IDLE) && ReadEnable && hit_any && !Invalidate;
    assign lookup_miss = (state == S_IDLE) && ReadEnable && !lookup_hit;

    // Line storage: beats written during refill, tag written with the last beat
    always_ff @(posedge Clk) begin
        if ((state == S_REFILL) && MemDataReady) begin
            data_mem[lat_set][lat_way][beat] <= MemDataIn;
            if (beat == LAST_BEAT) begin
                tag_mem[lat_set][lat_way] <= lat_tag;
            end
        end
    end

    // Control FSM with registered outputs, valid bits and replacement pointers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state          <= S_IDLE;
            Instruction    <= '0;
            Ready          <= 1'b0;
            Busy           <= 1'b0;
            MemReadAddress <= '0;
            MemReadRequest <= 1'b0;
            beat           <= '0;
            lat_set        <= '0;
            lat_tag        <= '0;
            lat_word       <= '0;
            lat_way        <= '0;
            lat_from_rr    <= 1'b0;
            poisoned       <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_ptr[s]  <= '0;
            end
        end else begin
            Ready <= 1'b0;
            if (Invalidate) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end
            case (state)
                S_IDLE: begin
                    if (lookup_hit) begin
                        Instruction <= data_mem[req_set][hit_way][req_word];
                        Ready       <= 1'b1;
                    end else if (lookup_miss) begin
                        state          <= S_REFILL;
                        Busy           <= 1'b1;
                        MemReadRequest <= 1'b1;
                        MemReadAddress <= {ReadAddress[31:OFFSET], {OFFSET{1'b0}}};
                        lat_set        <= req_set;
                        lat_tag        <= req_tag;
                        lat_word       <= req_word;
                        lat_way        <= victim_way;
                        lat_from_rr    <= victim_from_rr;
                        poisoned       <= 1'b0;
                        beat           <= '0;
                        // the victim's old contents are overwritten from the first beat on
                        if (!Invalidate) begin
                            valid_q[req_set][victim_way] <= 1'b0;
                        end
                    end
                end
                S_REFILL: begin
                    if (Invalidate) begin
                        poisoned <= 1'b1;
                    end
                    if (MemDataReady) begin
                        if (beat == lat_word) begin
                            Instruction <= MemDataIn;
                            Ready       <= 1'b1;
                        end
                        if (beat == LAST_BEAT) begin
                            state          <= S_IDLE;
                            Busy           <= 1'b0;
                            MemReadRequest <= 1'b0;
                            beat           <= '0;
                            if (!poisoned && !Invalidate) begin
                                valid_q[lat_set][lat_way] <= 1'b1;
                            end
                            if (lat_from_rr) begin
                                rr_ptr[lat_set] <= rr_ptr[lat_set] + 1'b1;
                            end
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating lookup statistics, untouched by Invalidate
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            if (lookup_hit && (HitCount != 32'hFFFF_FFFF)) begin
                HitCount <= HitCount + 32'd1;
            end
            if (lookup_miss && (MissCount != 32'hFFFF_FFFF)) begin
                MissCount <= MissCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ucsbece154_icache_rr.sv
// Directed bench for ucsbece154_icache_rr (8 sets, 4 ways, 4-word lines).
module tb_ucsbece154_icache_rr;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        ReadEnable = 1'b0;
    logic [31:0] ReadAddress = '0;
    logic        Invalidate = 1'b0;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] MemDataIn = '0;
    logic        MemDataReady = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0] HitCount;
    logic [31:0] MissCount;
    logic [31:0] miss_before;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int          rdy_cnt;
    logic [31:0] rdy_data;
    logic        rdy_busy;
    int          rdy_beat;

    ucsbece154_icache_rr #(
        .NUM_SETS(8), .NUM_WAYS(4), .BLOCK_WORDS(4), .WORD_SIZE(32)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .ReadEnable(ReadEnable),
        .ReadAddress(ReadAddress),
        .Invalidate(Invalidate),
        .Instruction(Instruction),
        .Ready(Ready),
        .Busy(Busy),
        .MemReadAddress(MemReadAddress),
        .MemReadRequest(MemReadRequest),
        .MemDataIn(MemDataIn),
        .MemDataReady(MemDataReady)
`ifdef ICACHE_STATS_EN
        ,
        .HitCount(HitCount),
        .MissCount(MissCount)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset        = 1'b0;
        ReadEnable   = 1'b0;
        Invalidate   = 1'b0;
        MemDataReady = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic read_req(input logic [31:0] a);
        ReadAddress = a;
        ReadEnable  = 1'b1;
        tick();
        ReadEnable  = 1'b0;
    endtask

    // Deliver one 4-beat line (beat i = base+i) with an idle cycle between
    // beats; optionally pulse Invalidate on one beat and toggle requests.
    task automatic feed_line(input logic [31:0] base, input int inv_beat, input bit poke,
                             output int cnt, output logic [31:0] data,
                             output logic busy_at, output int beat_at);
        cnt = 0; data = '0; busy_at = 1'b0; beat_at = -1;
        for (int i = 0; i < 4; i++) begin
            MemDataIn    = base + 32'(i);
            MemDataReady = 1'b1;
            Invalidate   = (i == inv_beat);
            if (poke) begin
                ReadEnable  = i[0];
                ReadAddress = 32'h0000_0080 + 32'(i) * 32'h10;
            end
            tick();
            MemDataReady = 1'b0;
            Invalidate   = 1'b0;
            if (Ready) begin
                cnt++; data = Instruction; busy_at = Busy; beat_at = i;
            end
            if (i != 3) begin
                if (poke) begin
                    ReadEnable  = ~i[0];
                    ReadAddress = 32'h0000_0504;
                end
                tick();
                if (Ready) cnt++;
            end
        end
        ReadEnable = 1'b0;
    endtask

    initial begin
        // reset state, observed while reset is held
        #3;
        check_eq("rst_instr", Instruction, 32'h0);
        check_eq("rst_ready", {31'b0, Ready}, 32'h0);
        check_eq("rst_busy", {31'b0, Busy}, 32'h0);
        check_eq("rst_mem_addr", MemReadAddress, 32'h0);
        check_eq("rst_mem_req", {31'b0, MemReadRequest}, 32'h0);

        // 1. cold miss, early restart on word 1, then hits
        apply_reset();
        MemDataReady = 1'b1;  // beat while idle must be ignored
        tick();
        MemDataReady = 1'b0;
        read_req(32'h0000_0104);
        check_eq("t1_busy", {31'b0, Busy}, 32'h1);
        check_eq("t1_req", {31'b0, MemReadRequest}, 32'h1);
        check_eq("t1_addr", MemReadAddress, 32'h0000_0100);
        check_eq("t1_ready0", {31'b0, Ready}, 32'h0);
        feed_line(32'hA000_0000, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        check_eq("t1_rdy_cnt", 32'(rdy_cnt), 32'd1);
        check_eq("t1_rdy_data", rdy_data, 32'hA000_0001);
        check_eq("t1_rdy_beat", 32'(rdy_beat), 32'd1);
        check_eq("t1_rdy_busy", {31'b0, rdy_busy}, 32'h1);
        check_eq("t1_busy_end", {31'b0, Busy}, 32'h0);
        check_eq("t1_req_end", {31'b0, MemReadRequest}, 32'h0);
        read_req(32'h0000_010C);
        check_eq("t1_hit_ready", {31'b0, Ready}, 32'h1);
        check_eq("t1_hit_data", Instruction, 32'hA000_0003);
        check_eq("t1_hit_noreq", {31'b0, MemReadRequest}, 32'h0);
        ReadEnable = 1'b1; ReadAddress = 32'h0000_0100;
        tick();
        check_eq("t1_b2b_a_data", Instruction, 32'hA000_0000);
        ReadAddress = 32'h0000_0108;
        tick();
        check_eq("t1_b2b_b_ready", {31'b0, Ready}, 32'h1);
        check_eq("t1_b2b_b_data", Instruction, 32'hA000_0002);
        ReadAddress = 32'h0000_0104; Invalidate = 1'b1;
        tick();
        ReadEnable = 1'b0; Invalidate = 1'b0;
        check_eq("t1_inv_hit_busy", {31'b0, Busy}, 32'h1);
        check_eq("t1_inv_hit_ready", {31'b0, Ready}, 32'h0);
        feed_line(32'hA100_0000, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        check_eq("t1_inv_refill_data", rdy_data, 32'hA100_0001);

        // 2. early restart on the last word
        apply_reset();
        read_req(32'h0000_020C);
        feed_line(32'hB000_0000, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        check_eq("t2_rdy_cnt", 32'(rdy_cnt), 32'd1);
        check_eq("t2_rdy_data", rdy_data, 32'hB000_0003);
        check_eq("t2_rdy_busy", {31'b0, rdy_busy}, 32'h0);

        // 3. round-robin replacement in set 0
        apply_reset();
        for (int t = 1; t <= 4; t++) begin
            read_req(32'(t) * 32'h80);
            feed_line(32'hC000_0000 + 32'(t) * 32'h100, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        end
        read_req(32'h0000_0280);
        check_eq("t3_280_miss", {31'b0, Busy}, 32'h1);
        feed_line(32'hC000_0500, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        read_req(32'h0000_0100);
        check_eq("t3_100_hit_ready", {31'b0, Ready}, 32'h1);
        check_eq("t3_100_hit_busy", {31'b0, Busy}, 32'h0);
        check_eq("t3_100_hit_data", Instruction, 32'hC000_0200);
        read_req(32'h0000_0080);
        check_eq("t3_080_miss", {31'b0, Busy}, 32'h1);
        feed_line(32'hC000_0600, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        read_req(32'h0000_0184);
        check_eq("t3_184_hit_data", Instruction, 32'hC000_0301);

        // 4. Invalidate during beat 1 of a refill
        apply_reset();
        read_req(32'h0000_0080);
        feed_line(32'hD000_0000, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        read_req(32'h0000_0300);
        feed_line(32'hD000_0100, 1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        check_eq("t4_rdy_cnt", 32'(rdy_cnt), 32'd1);
        check_eq("t4_rdy_data", rdy_data, 32'hD000_0100);
        read_req(32'h0000_0300);
        check_eq("t4_300_miss", {31'b0, Busy}, 32'h1);
        feed_line(32'hD000_0200, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        read_req(32'h0000_0080);
        check_eq("t4_080_miss", {31'b0, Busy}, 32'h1);
        feed_line(32'hD000_0300, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);

        // 5. asynchronous reset mid-refill
        apply_reset();
        read_req(32'h0000_0408);
        for (int i = 0; i < 3; i++) begin
            MemDataIn = 32'hE000_0000 + 32'(i);
            MemDataReady = 1'b1;
            tick();
        end
        MemDataReady = 1'b0;
        check_eq("t5_rdy_before", {31'b0, Ready}, 32'h1);
        check_eq("t5_data_before", Instruction, 32'hE000_0002);
        #2 Reset = 1'b0;
        #1;
        check_eq("t5_async_req", {31'b0, MemReadRequest}, 32'h0);
        check_eq("t5_async_busy", {31'b0, Busy}, 32'h0);
        check_eq("t5_async_ready", {31'b0, Ready}, 32'h0);
        tick();
        Reset = 1'b1;
        tick();
        read_req(32'h0000_0408);
        check_eq("t5_re_miss", {31'b0, Busy}, 32'h1);
        feed_line(32'hE100_0000, -1, 1'b0, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        check_eq("t5_re_beat", 32'(rdy_beat), 32'd2);
        check_eq("t5_re_data", rdy_data, 32'hE100_0002);

        // 6. requests toggling while busy are ignored
        apply_reset();
`ifdef ICACHE_STATS_EN
        miss_before = MissCount;
`endif
        read_req(32'h0000_0504);
        feed_line(32'hF000_0000, -1, 1'b1, rdy_cnt, rdy_data, rdy_busy, rdy_beat);
        check_eq("t6_rdy_cnt", 32'(rdy_cnt), 32'd1);
        check_eq("t6_rdy_data", rdy_data, 32'hF000_0001);
        tick();
        check_eq("t6_no_req", {31'b0, MemReadRequest}, 32'h0);
        check_eq("t6_no_ready", {31'b0, Ready}, 32'h0);
`ifdef ICACHE_STATS_EN
        check_eq("t6_miss_count", MissCount - miss_before, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ucsbece154_icache_rr.md
Name: ucsbece154_icache_rr

Overview:
Parametrised set-associative instruction cache; successor to the current fetch-side icache. Sits between the core fetch stage and the SDRAM controller. Adds the following over the current icache:
- explicit IDLE/REFILL FSM
- per-set round-robin replacement
- early restart: the requested word is forwarded as soon as its beat arrives
- whole-cache Invalidate for fence.i
- BLOCK_WORDS generalised to any power of two ≥2

Parameters:
NUM_SETS, 8, number of sets (power of two, ≥2)
NUM_WAYS, 4, ways per set (power of two, ≥2)
BLOCK_WORDS, 4, 32-bit words per line (power of two, ≥2)
WORD_SIZE, 32, instruction width (fixed 32)

Ports:
Clk  input  1  single clock, all state on rising edge
Reset  input  1  asynchronous active-low reset (0 = reset asserted)
ReadEnable  input  1  fetch request, sampled when Busy=0
ReadAddress  input  32  byte address; bits[1:0] ignored
Invalidate  input  1  one-cycle pulse: clear all valid bits
Instruction  output  32  fetched word, valid when Ready=1
Ready  output  1  one-cycle pulse per completed fetch
Busy  output  1  refill in progress; requests ignored
MemReadAddress  output  32  block-aligned refill address
MemReadRequest  output  1  held high for the entire refill
MemDataIn  input  32  refill beat data
MemDataReady  input  1  one pulse per beat; beats arrive in ascending word order from the aligned address

Behaviour:
- Address split:
  - OFFSET = 2 + log2(BLOCK_WORDS)
  - set = addr[OFFSET+log2(NUM_SETS)-1 : OFFSET]
  - tag = the remaining upper bits
  - word = addr[OFFSET-1 : 2]
- Reset (async, Reset=0):
  - Instruction=0, Ready=0, Busy=0, MemReadAddress=0, MemReadRequest=0
  - all valid bits=0, all RR pointers=0, FSM=IDLE, beat counter=0
  - Data/tag arrays need not be cleared.
- IDLE, hit:
  - ReadEnable=1 and tag matches a valid way in cycle N.
  - Cycle N+1: Instruction=data[set][way][word], Ready=1.
  - Back-to-back hits are sustained every cycle.
- IDLE, miss, cycle N:
  - Latch address.
  - Choose victim: lowest-index invalid way; if none, the set's RR pointer.
- IDLE, miss, cycle N+1:
  - FSM=REFILL, Busy=1, MemReadRequest=1.
  - MemReadAddress = {addr[31:OFFSET], OFFSET'b0}.
  - Ready=0.
- REFILL:
  - Each MemDataReady writes MemDataIn into data[set][victim][beat], then beat++.
  - Early restart: on the beat where beat == latched word, the next cycle has Instruction=MemDataIn, Ready=1. Busy stays 1.
  - Exactly one Ready per miss.
  - Last beat (beat == BLOCK_WORDS-1), next cycle:
    - tag written; valid set unless the line was poisoned
    - RR pointer of the set incremented mod NUM_WAYS, but only if the victim came from the pointer
    - MemReadRequest=0, Busy=0, FSM=IDLE, beat=0
- ReadEnable while Busy=1: ignored. The core holds its request.
- The first request after Busy falls is looked up normally and hits if it targets the just-filled line.
- MemDataReady in IDLE: ignored.
- Invalidate:
  - IDLE: all valid bits cleared next cycle. If coincident with ReadEnable, Invalidate wins and the access is treated as a miss.
  - REFILL: valid bits cleared; the in-flight line is poisoned. The refill still completes all beats and still delivers its early-restart word, but the line is not validated.
- Reset mid-refill: immediate return to reset state; the controller sees MemReadRequest drop.
- Ready is never asserted in the same cycle as a new miss being latched.

Optional Feature:
Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs HitCount[31:0] and MissCount[31:0].
  - Counters are reset to 0 and saturate at 0xFFFF_FFFF.
  - HitCount increments per hit lookup; MissCount increments per miss accepted.
  - Invalidate does not clear them.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
Configuration for all scenarios: NUM_SETS=8, NUM_WAYS=4, BLOCK_WORDS=4.
1. Cold miss then hit:
   - Stimulus: read 0x0000_0104.
   - Required:
     - MemReadAddress=0x0000_0100.
     - Beats {A0,A1,A2,A3} → Ready with Instruction=A1 the cycle after beat 1.
     - Busy drops after beat 3.
     - Read 0x0000_010C → Ready next cycle with A3, no MemReadRequest.
2. Early restart on last word:
   - Stimulus: read 0x0000_020C.
   - Required: exactly one Ready, Instruction = beat 3 data, in the same cycle Busy falls.
3. Round-robin replacement:
   - Stimulus: fill set 0 with tags 1..4 (0x080, 0x100, 0x180, 0x200), then miss on 0x280.
   - Required: way 0 is evicted. A re-read of 0x080 misses; a re-read of 0x100 hits.
4. Invalidate mid-refill:
   - Stimulus: pulse Invalidate during beat 1 of a refill of 0x300.
   - Required: Ready still occurs. A subsequent read of 0x300 misses again, and all previously cached lines miss.
5. Async reset mid-refill:
   - Stimulus: drive Reset=0 after beat 2.
   - Required: MemReadRequest, Busy and Ready go 0 without a clock edge; a later read of the same address misses.
6. Busy gating:
   - Stimulus: toggle ReadEnable with varying addresses during a refill.
   - Required: no extra MemReadRequest and no spurious Ready. With ICACHE_STATS_EN, MissCount increments by exactly 1.
